// File: rtl/rgb_layer_compositor.sv
// rtl/rgb_layer_compositor.sv - fixed-priority RGB layer compositor for the VGA output path
//
// Two-stage pipeline advanced by p_tick:
//   stage A registers the per-layer visibility vector, layer colours and display_on;
//   stage B registers the priority-selected colour, winner flag and winner index.
// Layer 0 has the highest priority. Output is blanked (0) outside the display window
// and shows BG_COLOR inside the window when no layer is visible.
//
// Optional feature macro: RGB_COMP_BLINK_EN
//   defined   - a BLINK_W-bit frame counter (advanced by frame_tick) drives blink_phase;
//               layers with blink_en set are hidden while blink_phase is 1.
//   undefined - no frame counter; blink_phase is 0; frame_tick and blink_en have no effect.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous reset, active low
//   p_tick      pixel-enable strobe; pipeline advances only when high
//   frame_tick  one-cycle pulse once per frame
//   display_on  current pixel is inside the visible area
//   layer_on    bit i: current pixel lies inside layer i
//   layer_rgb   layer i colour at [i*COLOR_W +: COLOR_W]
//   key_en      bit i: apply transparency key to layer i
//   key_rgb     per-layer transparency key, same packing as layer_rgb
//   blink_en    bit i: layer i is subject to blinking
//   rgb_out     composited pixel colour (registered)
//   sel_valid   a layer (not background) won the pixel
//   sel_idx     index of the winning layer; 0 when sel_valid is 0

module rgb_layer_compositor #(
    parameter int                 NUM_LAYERS = 8,
    parameter int                 COLOR_W    = 12,
    parameter logic [COLOR_W-1:0] BG_COLOR   = 12'h220,
    parameter int                 BLINK_W    = 4,
    parameter int                 IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          p_tick,
    input  logic                          frame_tick,
    input  logic                          display_on,
    input  logic [NUM_LAYERS-1:0]         layer_on,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]         key_en,
    input  logic [NUM_LAYERS*COLOR_W-1:0] key_rgb,
    input  logic [NUM_LAYERS-1:0]         blink_en,
    output logic [COLOR_W-1:0]            rgb_out,
    output logic                          sel_valid,
    output logic [IDX_W-1:0]              sel_idx
);

    logic blink_phase;

`ifdef RGB_COMP_BLINK_EN
    // Free-running frame counter; its MSB splits the period into a shown half
    // and a suppressed half. Runs independently of p_tick.
    logic [BLINK_W-1:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign blink_phase = frame_cnt[BLINK_W-1];
`else
    logic unused_frame_tick;

    assign blink_phase       = 1'b0;
    assign unused_frame_tick = frame_tick;
`endif

    // Visibility from the current inputs and the pre-increment blink phase.
    logic [NUM_LAYERS-1:0] vis_c;

    always_comb begin
        vis_c = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            vis_c[i] = layer_on[i]
                && !(key_en[i] && (layer_rgb[i*COLOR_W +: COLOR_W] == key_rgb[i*COLOR_W +: COLOR_W]))
                && !(blink_en[i] && blink_phase);
        end
    end

    // Stage A
    logic [NUM_LAYERS-1:0]         vis_a;
    logic [NUM_LAYERS*COLOR_W-1:0] rgb_a;
    logic                          disp_a;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vis_a  <= '0;
            rgb_a  <= '0;
            disp_a <= 1'b0;
        end else if (p_tick) begin
            vis_a  <= vis_c;
            rgb_a  <= layer_rgb;
            disp_a <= display_on;
        end
    end

    // Fixed-priority select: scanning from the top index down lets the lowest
    // visible index overwrite any earlier match.
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [COLOR_W-1:0] win_rgb;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_rgb   = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (vis_a[i]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
                win_rgb   = rgb_a[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // Stage B
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_out   <= '0;
            sel_valid <= 1'b0;
            sel_idx   <= '0;
        end else if (p_tick) begin
            if (!disp_a) begin
                rgb_out   <= '0;
                sel_valid <= 1'b0;
                sel_idx   <= '0;
            end else if (win_valid) begin
                rgb_out   <= win_rgb;
                sel_valid <= 1'b1;
                sel_idx   <= win_idx;
            end else begin
                rgb_out   <= BG_COLOR;
                sel_valid <= 1'b0;
                sel_idx   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rgb_layer_compositor.sv
// tb/tb_rgb_layer_compositor.sv - self-checking bench for rgb_layer_compositor
module tb_rgb_layer_compositor;

    localparam int N  = 8;
    localparam int C  = 12;
    localparam int BW = 4;
    localparam int IW = 3;
    localparam logic [C-1:0] BG = 12'h220;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, p_tick, frame_tick, display_on;
    logic [N-1:0]   layer_on, key_en, blink_en;
    logic [N*C-1:0] layer_rgb, key_rgb;
    logic [C-1:0]   rgb_out;
    logic           sel_valid;
    logic [IW-1:0]  sel_idx;

    int total = 0;
    int bad   = 0;
    int frames = 0;

    logic [C+IW:0] exp_q;
    logic [C+IW:0] pend_q;
    logic [C+IW:0] obs;
    assign obs = {rgb_out, sel_valid, sel_idx};

    rgb_layer_compositor #(
        .NUM_LAYERS(N), .COLOR_W(C), .BG_COLOR(BG), .BLINK_W(BW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .p_tick(p_tick), .frame_tick(frame_tick),
        .display_on(display_on), .layer_on(layer_on), .layer_rgb(layer_rgb),
        .key_en(key_en), .key_rgb(key_rgb), .blink_en(blink_en),
        .rgb_out(rgb_out), .sel_valid(sel_valid), .sel_idx(sel_idx)
    );

    // Reference pixel for the current inputs: {rgb, valid, idx}.
    function automatic logic [C+IW:0] ref_pixel();
        logic phase;
`ifdef RGB_COMP_BLINK_EN
        phase = (frames >= (1 << (BW - 1)));
`else
        phase = 1'b0;
`endif
        if (!display_on) return '0;
        for (int i = 0; i < N; i++) begin
            logic [C-1:0] col;
            col = layer_rgb[i*C +: C];
            if (!layer_on[i]) continue;
            if (key_en[i] && col == key_rgb[i*C +: C]) continue;
            if (blink_en[i] && phase) continue;
            return {col, 1'b1, IW'(i)};
        end
        return {BG, 1'b0, {IW{1'b0}}};
    endfunction

    // Advance one clock, updating the model with the inputs present at the edge.
    task automatic tick();
        logic [C+IW:0] nxt;
        nxt = ref_pixel();
        if (!rst_n) begin
            exp_q  = '0;
            pend_q = '0;
            frames = 0;
        end else begin
            if (p_tick) begin
                exp_q  = pend_q;
                pend_q = nxt;
            end
            if (frame_tick) frames = (frames + 1) % (1 << BW);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        layer_on   = N'($urandom);
        key_en     = N'($urandom);
        blink_en   = N'($urandom);
        display_on = ($urandom_range(0, 7) != 0);
        for (int i = 0; i < N; i++) begin
            logic [C-1:0] col;
            col = C'($urandom_range(0, 3) * 12'h555);
            layer_rgb[i*C +: C] = col;
            key_rgb[i*C +: C]   = $urandom_range(0, 1) ? col : C'($urandom);
        end
    endtask

    task automatic clear_inputs();
        layer_on = '0; key_en = '0; blink_en = '0;
        layer_rgb = '0; key_rgb = '0;
        display_on = 1'b1; frame_tick = 1'b0; p_tick = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; p_tick = 1'b1; frame_tick = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            tick();
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%h want=0", k, obs);
            end
        end
        rst_n = 1'b1;
        rand_inputs();
        tick();
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_first_ptick got=%h want=0", obs);
        end
    endtask

    task automatic test_priority();
        clear_inputs();
        layer_on = 8'b0010_0100;
        layer_rgb[2*C +: C] = 12'hF00;
        layer_rgb[5*C +: C] = 12'h0F0;
        tick(); tick();
        total++;
        if (obs !== {12'hF00, 1'b1, 3'd2}) begin
            bad++;
            $display("FAIL priority got=%h want=%h", obs, {12'hF00, 1'b1, 3'd2});
        end
    endtask

    task automatic test_transparency();
        key_en = 8'b0000_0100;
        key_rgb[2*C +: C] = 12'hF00;
        tick(); tick();
        total++;
        if (obs !== {12'h0F0, 1'b1, 3'd5}) begin
            bad++;
            $display("FAIL key_skip got=%h want=%h", obs, {12'h0F0, 1'b1, 3'd5});
        end
        layer_on[5] = 1'b0;
        tick(); tick();
        total++;
        if (obs !== {BG, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL background got=%h want=%h", obs, {BG, 1'b0, 3'd0});
        end
    endtask

    task automatic test_blanking();
        clear_inputs();
        display_on = 1'b0;
        layer_on = '1;
        layer_rgb = {N{12'h123}};
        tick(); tick();
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL blank got=%h want=0", obs);
        end
        p_tick = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rand_inputs();
            display_on = 1'b1;
            tick();
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL hold cyc=%0d got=%h want=0", k, obs);
            end
        end
    endtask

    task automatic test_blink();
        logic [C+IW:0] want_hidden;
        clear_inputs();
        layer_on = 8'b1;
        layer_rgb[0 +: C] = 12'hABC;
        blink_en = 8'b1;
        tick(); tick();
        total++;
        if (obs !== {12'hABC, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL blink_start got=%h want=%h", obs, {12'hABC, 1'b1, 3'd0});
        end
`ifdef RGB_COMP_BLINK_EN
        want_hidden = {BG, 1'b0, 3'd0};
`else
        want_hidden = {12'hABC, 1'b1, 3'd0};
`endif
        for (int half = 0; half < 2; half++) begin
            for (int k = 0; k < 8; k++) begin
                frame_tick = 1'b1;
                tick();
                frame_tick = 1'b0;
                tick();
                total++;
                if (obs !== exp_q) begin
                    bad++;
                    $display("FAIL blink_step h=%0d k=%0d got=%h want=%h", half, k, obs, exp_q);
                end
            end
            tick(); tick();
            total++;
            if (half == 0 && obs !== want_hidden) begin
                bad++;
                $display("FAIL blink_suppressed got=%h want=%h", obs, want_hidden);
            end else if (half == 1 && obs !== {12'hABC, 1'b1, 3'd0}) begin
                bad++;
                $display("FAIL blink_wrap got=%h want=%h", obs, {12'hABC, 1'b1, 3'd0});
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            rand_inputs();
            p_tick     = ($urandom_range(0, 3) != 0);
            frame_tick = ($urandom_range(0, 4) == 0);
            rst_n      = ($urandom_range(0, 79) != 0);
            tick();
            total++;
            if (obs !== exp_q) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", k, obs, exp_q);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_priority();
        test_transparency();
        test_blanking();
        test_blink();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
